// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, colour types and RGB332 expansion helpers
// for the 640x480@60 pixel scanner.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int COORD_W = 11;

    // Renderer colour word as delivered on pixelRGB.
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Per-coordinate control bits that travel alongside the renderer latency.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } raster_ctl_t;

    // 3-bit channel to 8 bits by bit replication so full scale maps to 8'hFF.
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    // 2-bit channel to 8 bits by bit replication.
    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a parameterised reset value; used to hold
// decoded raster control bits until the renderer colour for the same
// coordinate arrives.
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; every stage returns to RESET_VAL on reset.
    // NOTE: this is a handful of flops, not a RAM, so resetting every stage is
    // cheap and guarantees blank/inactive sync while the pipe refills.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            // NOTE: non-blocking assignment makes every stage sample the old
            // value of its predecessor, giving a true shift rather than a
            // single-cycle ripple-through.
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_scanner.sv
// Raster timing master: issues pixel coordinates to the renderers, lines up
// their registered RGB332 result with delayed blank/sync, and drives the VGA
// outputs through a final output register.
module vga_pixel_scanner
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = H_ACTIVE_DEF,
    parameter int   H_FP       = H_FP_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BP       = H_BP_DEF,
    parameter int   V_ACTIVE   = V_ACTIVE_DEF,
    parameter int   V_FP       = V_FP_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BP       = V_BP_DEF,
    parameter int   RENDER_LAT = 1,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] pixelX,
    output logic [COORD_W-1:0] pixelY,
    input  logic [7:0]         pixelRGB,
    output logic               startOfFrame,
    output logic [7:0]         vgaR,
    output logic [7:0]         vgaG,
    output logic [7:0]         vgaB,
    output logic               vgaHS,
    output logic               vgaVS,
    output logic               vgaBlank
);

    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [COORD_W-1:0] H_VIS     = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS     = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               sof_q, sof_d;
    // Low only between reset release and the first edge, which presents (0,0).
    logic               run_q;

    raster_ctl_t ctl_issue, ctl_late;
    rgb332_t     rgb;

    logic [7:0] vga_r_q, vga_g_q, vga_b_q;
    logic       vga_hs_q, vga_vs_q, vga_blank_q;

    // Next raster position; the first edge after reset only announces (0,0).
    // NOTE: every output gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        sof_d = 1'b0;
        if (!run_q) begin
            x_d   = '0;
            y_d   = '0;
            sof_d = 1'b1;
        end else begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
            sof_d = (x_d == '0) && (y_d == '0);
        end
    end

    // Raster counters and start-of-frame flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            sof_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            sof_q <= sof_d;
            run_q <= 1'b1;
        end
    end

    // Decode the coordinate currently issued; nothing is issued before run_q.
    always_comb begin
        ctl_issue.active = run_q && (x_q < H_VIS) && (y_q < V_VIS);
        ctl_issue.hs     = run_q && (x_q >= HS_START) && (x_q < HS_END);
        ctl_issue.vs     = run_q && (y_q >= VS_START) && (y_q < VS_END);
    end

    vga_delay_line #(
        .WIDTH     ($bits(raster_ctl_t)),
        .DEPTH     (RENDER_LAT),
        .RESET_VAL ('0)
    ) u_ctl_delay (
        .clk    (clk),
        .reset  (reset),
        .data_i (ctl_issue),
        .data_o (ctl_late)
    );

    assign rgb = rgb332_t'(pixelRGB);

    // Output register: expand colour, gate it by delayed active, map sync levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_r_q     <= '0;
            vga_g_q     <= '0;
            vga_b_q     <= '0;
            vga_hs_q    <= ~SYNC_POL;
            vga_vs_q    <= ~SYNC_POL;
            vga_blank_q <= 1'b1;
        end else begin
            vga_r_q     <= ctl_late.active ? expand3(rgb.r) : 8'h00;
            vga_g_q     <= ctl_late.active ? expand3(rgb.g) : 8'h00;
            vga_b_q     <= ctl_late.active ? expand2(rgb.b) : 8'h00;
            vga_hs_q    <= ctl_late.hs ? SYNC_POL : ~SYNC_POL;
            vga_vs_q    <= ctl_late.vs ? SYNC_POL : ~SYNC_POL;
            vga_blank_q <= ~ctl_late.active;
        end
    end

    assign pixelX       = x_q;
    assign pixelY       = y_q;
    assign startOfFrame = sof_q;
    assign vgaR         = vga_r_q;
    assign vgaG         = vga_g_q;
    assign vgaB         = vga_b_q;
    assign vgaHS        = vga_hs_q;
    assign vgaVS        = vga_vs_q;
    assign vgaBlank     = vga_blank_q;

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Directed bench for vga_pixel_scanner: three instances (full timing with
// RENDER_LAT 1 and 3, plus a shrunken raster with RENDER_LAT 2 and positive
// sync so whole frames fit in a short run), each fed by a registered renderer.
module tb_vga_pixel_scanner;

    typedef struct packed {
        int   ha; int hf; int hs; int hb;
        int   va; int vf; int vs; int vb;
        int   lat;
        logic pol;
    } cfg_t;

    typedef struct packed {
        logic       blank;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } out_t;

    localparam cfg_t CFG1 = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, lat:1, pol:1'b0};
    localparam cfg_t CFG3 = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, lat:3, pol:1'b0};
    localparam cfg_t CFGS = '{ha:16, hf:2, hs:3, hb:3, va:6, vf:1, vs:2, vb:1, lat:2, pol:1'b1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Renderer behaviour: 0 -> colour is pixelX[7:0], 1 -> constant rconst.
    logic       rmode = 1'b0;
    logic [7:0] rconst = 8'h00;

    logic [10:0] px1, py1, px3, py3, pxs, pys;
    logic [7:0]  rgb1, rgb3, rgbs;
    logic        sof1, sof3, sofs;
    logic [7:0]  r1, g1, b1, r3, g3, b3, rs, gs, bs;
    logic        hs1, vs1, bl1, hs3, vs3, bl3, hss, vss, bls;
    logic [7:0]  rnd3_a, rnd3_b, rnds_a;

    vga_pixel_scanner #(.RENDER_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .pixelX(px1), .pixelY(py1), .pixelRGB(rgb1),
        .startOfFrame(sof1), .vgaR(r1), .vgaG(g1), .vgaB(b1),
        .vgaHS(hs1), .vgaVS(vs1), .vgaBlank(bl1));

    vga_pixel_scanner #(.RENDER_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .pixelX(px3), .pixelY(py3), .pixelRGB(rgb3),
        .startOfFrame(sof3), .vgaR(r3), .vgaG(g3), .vgaB(b3),
        .vgaHS(hs3), .vgaVS(vs3), .vgaBlank(bl3));

    vga_pixel_scanner #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .RENDER_LAT(2), .SYNC_POL(1'b1)
    ) duts (
        .clk(clk), .reset(reset), .pixelX(pxs), .pixelY(pys), .pixelRGB(rgbs),
        .startOfFrame(sofs), .vgaR(rs), .vgaG(gs), .vgaB(bs),
        .vgaHS(hss), .vgaVS(vss), .vgaBlank(bls));

    function automatic logic [7:0] render(input logic [10:0] x);
        return rmode ? rconst : x[7:0];
    endfunction

    // Registered renderers of depth 1, 3 and 2.
    always @(posedge clk) begin
        rgb1   <= render(px1);
        rnd3_a <= render(px3);
        rnd3_b <= rnd3_a;
        rgb3   <= rnd3_b;
        rnds_a <= render(pxs);
        rgbs   <= rnds_a;
    end

    // Expected {pixelX, pixelY, startOfFrame} after c edges since reset release.
    function automatic logic [22:0] exp_cnt(input int c, input cfg_t k);
        int ht, vt, n;
        ht = k.ha + k.hf + k.hs + k.hb;
        vt = k.va + k.vf + k.vs + k.vb;
        if (c < 1) return '0;
        n = c - 1;
        return {11'(n % ht), 11'((n / ht) % vt), n % (ht * vt) == 0};
    endfunction

    // Expected VGA outputs for raster pixel index n (n < 0 means reset state).
    function automatic out_t model(input int n, input cfg_t k);
        out_t o;
        int ht, vt, x, y;
        logic [7:0] c;
        ht = k.ha + k.hf + k.hs + k.hb;
        vt = k.va + k.vf + k.vs + k.vb;
        o.blank = 1'b1; o.hs = ~k.pol; o.vs = ~k.pol;
        o.r = 8'h00; o.g = 8'h00; o.b = 8'h00;
        if (n >= 0) begin
            x = n % ht;
            y = (n / ht) % vt;
            c = rmode ? rconst : 8'(x);
            if (x < k.ha && y < k.va) begin
                o.blank = 1'b0;
                o.r = {c[7:5], c[7:5], c[7:6]};
                o.g = {c[4:2], c[4:2], c[4:3]};
                o.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
            end
            if (x >= k.ha + k.hf && x < k.ha + k.hf + k.hs) o.hs = k.pol;
            if (y >= k.va + k.vf && y < k.va + k.vf + k.vs) o.vs = k.pol;
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("d1_cnt", {px1, py1, sof1}, exp_cnt(cyc, CFG1));
        check("d3_cnt", {px3, py3, sof3}, exp_cnt(cyc, CFG3));
        check("ds_cnt", {pxs, pys, sofs}, exp_cnt(cyc, CFGS));
        check("d1_out", {bl1, hs1, vs1, r1, g1, b1}, model(cyc - CFG1.lat - 2, CFG1));
        check("d3_out", {bl3, hs3, vs3, r3, g3, b3}, model(cyc - CFG3.lat - 2, CFG3));
        check("ds_out", {bls, hss, vss, rs, gs, bs}, model(cyc - CFGS.lat - 2, CFGS));
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_d1"}, {px1, py1, sof1, bl1, hs1, vs1, r1, g1, b1}, {23'h0, 3'b111, 24'h0});
        check({tag, "_d3"}, {px3, py3, sof3, bl3, hs3, vs3, r3, g3, b3}, {23'h0, 3'b111, 24'h0});
        check({tag, "_ds"}, {pxs, pys, sofs, bls, hss, vss, rs, gs, bs}, {23'h0, 3'b100, 24'h0});
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        // Phase 1: renderer returns pixelX[7:0].
        rmode = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst_init");
        release_reset();

        step();
        check("sof_first", {px1, sof1, bl1}, {11'd0, 1'b1, 1'b1});
        step();
        check("blank_c2", {px1, bl1, r1, g1, b1}, {11'd1, 1'b1, 24'h0});
        run_to(11);
        check("d1_x8_g", {bl1, g1}, {1'b0, 8'h49});
        run_to(13);
        check("d3_x8_g", {bl3, g3}, {1'b0, 8'h49});
        run_to(171);
        check("ds_vs_pre", vss, 1'b0);
        run_to(172);
        check("ds_vs_on", vss, 1'b1);
        run_to(219);
        check("ds_vs_last", vss, 1'b1);
        run_to(220);
        check("ds_vs_off", vss, 1'b0);
        run_to(240);
        check("ds_sof_pre", sofs, 1'b0);
        run_to(241);
        check("ds_sof_period", {sofs, pxs, pys}, {1'b1, 22'h0});
        run_to(642);
        check("d1_x639", {bl1, r1, g1, b1}, {1'b0, 8'h6D, 8'hFF, 8'hFF});
        run_to(643);
        check("d1_x640", {bl1, r1, g1, b1}, {1'b1, 24'h0});
        run_to(658);
        check("d1_hs_pre", hs1, 1'b1);
        run_to(659);
        check("d1_hs_on", hs1, 1'b0);
        run_to(754);
        check("d1_hs_last", hs1, 1'b0);
        run_to(755);
        check("d1_hs_off", hs1, 1'b1);
        run_to(1459);
        check("d1_hs_line1", hs1, 1'b0);
        run_to(1901);
        check("d1_pos_mid", {px1, py1}, {11'd300, 11'd2});

        // Mid-frame asynchronous reset: outputs return before any clock edge.
        reset = 1'b1;
        #1;
        check_reset_state("rst_async");
        @(negedge clk);
        check_reset_state("rst_hold");

        // Phase 2: constant blue 8'b000_000_10.
        rmode  = 1'b1;
        rconst = 8'b000_000_10;
        release_reset();
        step();
        check("sof_restart", {sof1, sof3, sofs}, 3'b111);
        run_to(813);
        check("d1_blue", {bl1, r1, g1, b1}, {1'b0, 8'h00, 8'h00, 8'hAA});
        run_to(815);
        check("d3_blue", {bl3, r3, g3, b3}, {1'b0, 8'h00, 8'h00, 8'hAA});
        run_to(1503);
        check("d1_x700_blank", {bl1, r1, g1, b1}, {1'b1, 24'h0});

        reset = 1'b1;
        #1;
        check_reset_state("rst_p2");
        @(negedge clk);

        // Phase 3: constant white.
        rconst = 8'hFF;
        release_reset();
        run_to(103);
        check("d1_white", {bl1, r1, g1, b1}, {1'b0, 24'hFFFFFF});
        run_to(105);
        check("d3_white", {bl3, r3, g3, b3}, {1'b0, 24'hFFFFFF});
        run_to(700);
        check("d1_white_x697", {bl1, r1, g1, b1}, {1'b1, 24'h0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
